// File: rtl/uart_tx_serializer_pkg.sv
// uart_pkg: shared FSM state type, line idle level and baud helper
// for the UART transmit serializer. No ports.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO-to-serializer link: empty, tx_data (head word), transmit_complete (pop).
// master = FIFO side, slave = serializer side.
interface uart_tx_serializer_if #(
  parameter int DW = 7
);
  import uart_pkg::*;

  logic          empty;
  logic [DW:0]   tx_data;
  logic          transmit_complete;

  modport master (
    output empty,
    output tx_data,
    input  transmit_complete
  );

  modport slave (
    input  empty,
    input  tx_data,
    output transmit_complete
  );

endinterface

// File: rtl/uart_tx_serializer_baud_counter.sv
// uart_baud_counter: bit-time counter; ports clk, reset (async, high),
// restart (sync clear), bit_done (high on the last clk of a bit time).
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_done = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and sends 8N1-style frames.
// Ports: clk, reset (async, high), fifo (slave), tx (line), busy. Macro UART_TX_PARITY_EN adds even parity.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DW        = 7,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_serializer_if.slave  fifo,
  output logic                 tx,
  output logic                 busy
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(DW + 2);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DW);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t   state;
  uart_state_t   state_n;
  logic [DW:0]   shreg;
  logic [DW:0]   shreg_n;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_cnt_n;
  logic          stop_cnt;
  logic          stop_cnt_n;
  logic          tx_n;
  logic          done;
  logic          bit_done;
  logic          restart;

`ifdef UART_TX_PARITY_EN
  logic          par;
  logic          par_n;
`endif

  // Counter sits at 0 through IDLE so START always begins a fresh bit.
  assign restart = (state == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CPB)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .bit_done (bit_done)
  );

  assign busy                   = (state != IDLE);
  assign fifo.transmit_complete = done;

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    done       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n      = par;
`endif
    unique case (state)
      IDLE: begin
        if (!fifo.empty) begin
          shreg_n = fifo.tx_data;
`ifdef UART_TX_PARITY_EN
          par_n   = ^fifo.tx_data;
`endif
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == LAST_BIT) begin
            stop_cnt_n = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_n    = PARITY;
`else
            state_n    = STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            shreg_n   = shreg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (stop_cnt == LAST_STOP) begin
            // Pop and return to IDLE on the same edge.
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // tx is registered from the next state so the line
  // changes on the same edge as the FSM.
  always_comb begin
    tx_n = IDLE_LEVEL;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      tx       <= tx_n;
`ifdef UART_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule
